// File: rtl/miner_pkg.sv
// Shared types and constants for the nonce scheduler and its helpers.
package miner_pkg;

  localparam int JOB_W       = 608;  // full job header carried to the core
  localparam int BLOCK_W     = 512;  // midstate / first block portion of the header
  localparam int NONCE_DEF_W = 32;   // nonce width of the standard job record

  // Scheduler phases: wait for job, issue nonces, wait for results, report completion.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } sched_state_e;

  // One job as offered by the host side.
  typedef struct packed {
    logic [JOB_W-1:0]       data;
    logic [NONCE_DEF_W-1:0] nonce_start;
    logic [NONCE_DEF_W-1:0] nonce_end;
  } job_t;

endpackage

// File: rtl/miner_inflight_ctr.sv
// Outstanding-hash counter: +1 per issued nonce, -1 per returned result.
// A return with nothing outstanding is flagged as underflow and ignored.
module miner_inflight_ctr #(
  parameter int MAX = 8,
  parameter int W   = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         full,
  output logic         empty,
  output logic         underflow
);

  logic dec_ok;

  assign dec_ok    = dec && (count != '0);
  assign underflow = dec && (count == '0);
  assign full      = (count == W'(MAX));
  assign empty     = (count == '0);

  // Simultaneous inc and valid dec cancel out; an underflowing dec leaves count alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc && !dec_ok) begin
      count <= count + 1'b1;
    end else if (!inc && dec_ok) begin
      count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/miner_nonce_sched.sv
// Job-level controller: latches a header job, issues its nonce range to the
// hash core one handshake at a time, counts results and reports hits.
module miner_nonce_sched
  import miner_pkg::*;
#(
  parameter int NONCE_W      = 32,
  parameter int MAX_INFLIGHT = 8,
  parameter int STOP_ON_HIT  = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               job_valid,
  output logic               job_ready,
  input  logic [JOB_W-1:0]   job_data,
  input  logic [NONCE_W-1:0] job_nonce_start,
  input  logic [NONCE_W-1:0] job_nonce_end,
  input  logic               job_abort,
  output logic [JOB_W-1:0]   core_data,
  output logic               core_req_valid,
  input  logic               core_req_ready,
  output logic [NONCE_W-1:0] core_req_nonce,
  input  logic               core_res_valid,
  input  logic               core_res_hit,
  input  logic [NONCE_W-1:0] core_res_nonce,
  output logic               found_valid,
  output logic [NONCE_W-1:0] found_nonce,
  output logic               busy,
  output logic               done,
  output logic [31:0]        hash_count,
  output logic               proto_err
);

  localparam int CNT_W = 8;

  sched_state_e       state;
  logic [NONCE_W-1:0] nxt;
  logic [NONCE_W-1:0] last;
  logic               hits_en;   // hits are reportable: scanning, or draining after range end
  logic [CNT_W-1:0]   inflight;
  logic               full;
  logic               empty;
  logic               underflow;
  logic               issue;
  logic               res_ok;
  logic               hit;
  logic               drained;

  assign issue   = core_req_valid && core_req_ready;
  assign res_ok  = core_res_valid && !underflow;
  assign hit     = res_ok && core_res_hit;
  // DRAIN never issues, so a single outstanding hash returning now empties the pipe.
  assign drained = empty || ((inflight == CNT_W'(1)) && res_ok);

  assign core_req_valid = (state == SCAN) && !full;
  assign core_req_nonce = nxt;
  assign job_ready      = (state == IDLE);
  assign busy           = (state != IDLE);
  assign done           = (state == DONE);

  miner_inflight_ctr #(
    .MAX (MAX_INFLIGHT),
    .W   (CNT_W)
  ) u_inflight (
    .clk       (clk),
    .rst_n     (rst_n),
    .inc       (issue),
    .dec       (core_res_valid),
    .count     (inflight),
    .full      (full),
    .empty     (empty),
    .underflow (underflow)
  );

  // Job FSM with nonce cursor, job latch and hit reporting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      core_data   <= '0;
      nxt         <= '0;
      last        <= '0;
      hits_en     <= 1'b0;
      found_valid <= 1'b0;
      found_nonce <= '0;
    end else begin
      found_valid <= hits_en && hit;
      if (hits_en && hit) begin
        found_nonce <= core_res_nonce;
      end
      case (state)
        IDLE: begin
          if (job_valid) begin
            core_data <= job_data;
            nxt       <= job_nonce_start;
            last      <= job_nonce_end;
            hits_en   <= 1'b1;
            state     <= SCAN;
          end
        end
        SCAN: begin
          // A handshake in the same cycle as abort or hit-stop is still honoured.
          if (issue) begin
            nxt <= nxt + 1'b1;
          end
          if (job_abort) begin
            hits_en <= 1'b0;
            state   <= DRAIN;
          end else if (issue && (nxt == last)) begin
            state <= DRAIN;
          end else if ((STOP_ON_HIT != 0) && hit) begin
            hits_en <= 1'b0;
            state   <= DRAIN;
          end
        end
        DRAIN: begin
          if (drained) begin
            hits_en <= 1'b0;
            state   <= DONE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Per-job result counter (saturating) and sticky protocol error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hash_count <= '0;
      proto_err  <= 1'b0;
    end else begin
      if ((state == IDLE) && job_valid) begin
        hash_count <= '0;
      end else if (res_ok && (hash_count != 32'hFFFF_FFFF)) begin
        hash_count <= hash_count + 1'b1;
      end
      if (underflow) begin
        proto_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_miner_nonce_sched.sv
// Self-checking bench for miner_nonce_sched: directed jobs plus a random job,
// with a behavioural core (latency queue) and a range-level expectation model.
module tb_miner_nonce_sched;
  import miner_pkg::*;

  localparam int NW   = 32;
  localparam int MAXI = 2;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            job_valid = 1'b0;
  logic            job_ready;
  logic [JOB_W-1:0] job_data = '0;
  logic [NW-1:0]   job_nonce_start = '0;
  logic [NW-1:0]   job_nonce_end = '0;
  logic            job_abort = 1'b0;
  logic [JOB_W-1:0] core_data;
  logic            core_req_valid;
  logic            core_req_ready = 1'b0;
  logic [NW-1:0]   core_req_nonce;
  logic            core_res_valid = 1'b0;
  logic            core_res_hit = 1'b0;
  logic [NW-1:0]   core_res_nonce = '0;
  logic            found_valid;
  logic [NW-1:0]   found_nonce;
  logic            busy;
  logic            done;
  logic [31:0]     hash_count;
  logic            proto_err;

  always #5 clk = ~clk;

  miner_nonce_sched #(
    .NONCE_W      (NW),
    .MAX_INFLIGHT (MAXI),
    .STOP_ON_HIT  (1)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .job_valid       (job_valid),
    .job_ready       (job_ready),
    .job_data        (job_data),
    .job_nonce_start (job_nonce_start),
    .job_nonce_end   (job_nonce_end),
    .job_abort       (job_abort),
    .core_data       (core_data),
    .core_req_valid  (core_req_valid),
    .core_req_ready  (core_req_ready),
    .core_req_nonce  (core_req_nonce),
    .core_res_valid  (core_res_valid),
    .core_res_hit    (core_res_hit),
    .core_res_nonce  (core_res_nonce),
    .found_valid     (found_valid),
    .found_nonce     (found_nonce),
    .busy            (busy),
    .done            (done),
    .hash_count      (hash_count),
    .proto_err       (proto_err)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    logic [NW-1:0] nonce;
    int            due;
  } pend_t;
  pend_t pend[$];

  task automatic check(input string tag, input logic [JOB_W-1:0] obs, input logic [JOB_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  function automatic job_t make_job(input logic [NW-1:0] s, input logic [NW-1:0] e);
    job_t j;
    for (int k = 0; k < JOB_W / 32; k++) begin
      j.data[k*32 +: 32] = $urandom();
    end
    j.nonce_start = s;
    j.nonce_end   = e;
    return j;
  endfunction

  // Runs one job to completion against the expectation model. Called at a negedge.
  task automatic run_job(input string name, input job_t job, input bit use_hit,
                         input logic [NW-1:0] hit_nonce, input int abort_at,
                         input int lat_min, input int lat_max, input int ready_pct,
                         input int hold_cycles, input int exp_issued, input int exp_found_cnt);
    logic [NW-1:0] exp_nonce;
    logic [NW-1:0] exp_found_nonce = '0;
    logic [NW-1:0] rn;
    bit scanning = 1'b1;
    bit report = 1'b1;
    bit exp_found_now = 1'b0;
    bit exp_found_next;
    bit done_seen = 1'b0;
    bit exp_valid, rdy, res_now, rhit, abrt, hs;
    int issued = 0;
    int results = 0;
    int found_cnt = 0;
    int t0;

    check({name, "_job_ready"}, job_ready, 1'b1);
    job_valid       = 1'b1;
    job_data        = job.data;
    job_nonce_start = job.nonce_start;
    job_nonce_end   = job.nonce_end;
    tick();
    job_valid       = 1'b0;
    job_data        = {JOB_W{1'b1}};
    check({name, "_core_data"}, core_data, job.data);
    check({name, "_busy"}, busy, 1'b1);
    check({name, "_hash_clr"}, hash_count, 32'd0);
    t0 = cyc;

    for (int b = 0; b < 3000 && !done_seen; b++) begin
      // Observe this cycle's outputs.
      check({name, "_found_valid"}, found_valid, exp_found_now);
      if (exp_found_now) begin
        check({name, "_found_nonce"}, found_nonce, exp_found_nonce);
        found_cnt++;
      end
      if (done) begin
        done_seen = 1'b1;
        check({name, "_done_drained"}, (pend.size() == 0) && !scanning, 1'b1);
        check({name, "_hash_count"}, hash_count, results);
      end else begin
        exp_valid = scanning && (pend.size() < MAXI);
        check({name, "_req_valid"}, core_req_valid, exp_valid);
        exp_nonce = job.nonce_start + NW'(issued);
        if (core_req_valid) begin
          check({name, "_req_nonce"}, core_req_nonce, exp_nonce);
        end
        // Choose this cycle's inputs.
        rdy     = ($urandom_range(99) < ready_pct);
        res_now = (pend.size() > 0) && (pend[0].due <= cyc) && ((cyc - t0) >= hold_cycles)
                  && ((ready_pct == 100) || ($urandom_range(3) != 0));
        rn      = res_now ? pend[0].nonce : $urandom();
        rhit    = res_now && use_hit && (rn == hit_nonce);
        hs      = core_req_valid && rdy;
        abrt    = (abort_at > 0) && hs && (issued == abort_at - 1);
        core_req_ready = rdy;
        core_res_valid = res_now;
        core_res_hit   = rhit;
        core_res_nonce = rn;
        job_abort      = abrt;
        // Expectation model update.
        exp_found_next = 1'b0;
        if (res_now) begin
          if (rhit && report) begin
            exp_found_next  = 1'b1;
            exp_found_nonce = rn;
          end
          void'(pend.pop_front());
          results++;
        end
        if (hs) begin
          pend.push_back('{nonce: exp_nonce, due: cyc + lat_min + $urandom_range(lat_max - lat_min)});
          issued++;
        end
        if (scanning) begin
          if (abrt) begin
            scanning = 1'b0;
            report   = 1'b0;
          end else if (hs && (exp_nonce == job.nonce_end)) begin
            scanning = 1'b0;
          end else if (rhit) begin
            scanning = 1'b0;
            report   = 1'b0;
          end
        end
        exp_found_now = exp_found_next;
        tick();
      end
    end
    core_req_ready = 1'b0;
    core_res_valid = 1'b0;
    core_res_hit   = 1'b0;
    job_abort      = 1'b0;
    check({name, "_done_seen"}, done_seen, 1'b1);
    if (exp_issued >= 0) begin
      check({name, "_issued"}, issued, exp_issued);
    end
    check({name, "_found_cnt"}, found_cnt, exp_found_cnt);
    $display("job %s: start=%08h end=%08h issued=%0d results=%0d hits=%0d cycles=%0d",
             name, job.nonce_start, job.nonce_end, issued, results, found_cnt, cyc - t0);
    tick();
    check({name, "_done_once"}, done, 1'b0);
    check({name, "_idle_ready"}, job_ready, 1'b1);
    pend.delete();
  endtask

  initial begin
    job_t j;
    logic [NW-1:0] rs;
    int rlen, hoff;

    // Reset state.
    @(negedge clk);
    check("rst_job_ready", job_ready, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_req_valid", core_req_valid, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_found_valid", found_valid, 1'b0);
    check("rst_found_nonce", found_nonce, 32'd0);
    check("rst_hash_count", hash_count, 32'd0);
    check("rst_proto_err", proto_err, 1'b0);
    check("rst_core_data", core_data, '0);
    rst_n = 1'b1;
    tick();

    // Basic range, fixed 3-cycle latency, core always ready.
    j = make_job(32'h10, 32'h13);
    run_job("range", j, 1'b0, 32'h0, 0, 3, 3, 100, 0, 4, 0);

    // Backpressure: results held so issue must stall at the inflight limit.
    j = make_job(32'h40, 32'h47);
    run_job("bpress", j, 1'b0, 32'h0, 0, 1, 2, 100, 8, 8, 0);

    // Hit-stop on 0x11 inside 0x10..0x1F.
    j = make_job(32'h10, 32'h1F);
    run_job("hit", j, 1'b1, 32'h11, 0, 3, 3, 100, 0, -1, 1);
    check("hit_found_held", found_nonce, 32'h11);

    // Range wrapping through all-ones.
    j = make_job(32'hFFFF_FFFE, 32'h1);
    run_job("wrap", j, 1'b0, 32'h0, 0, 1, 4, 100, 0, 4, 0);

    // Abort at the 3rd issue; the hit on that nonce returns during drain.
    j = make_job(32'h1000, 32'h1063);
    run_job("abort", j, 1'b1, 32'h1002, 3, 2, 4, 100, 0, 3, 0);

    // Single-nonce range.
    j = make_job(32'h55, 32'h55);
    run_job("single", j, 1'b0, 32'h0, 0, 1, 3, 100, 0, 1, 0);

    // Randomized jobs with random readiness, latency and hit position.
    for (int r = 0; r < 4; r++) begin
      rs   = $urandom();
      rlen = $urandom_range(40, 5);
      hoff = $urandom_range(rlen + 10);
      j = make_job(rs, rs + NW'(rlen - 1));
      run_job("rand", j, 1'b1, rs + NW'(hoff), 0, 1, 5, 70, 0, (hoff < rlen) ? -1 : rlen,
              (hoff < rlen) ? 1 : 0);
    end
    check("proto_clean", proto_err, 1'b0);

    // Reset asserted mid-scan.
    j = make_job(32'h200, 32'h2FF);
    job_valid = 1'b1;
    job_data = j.data;
    job_nonce_start = j.nonce_start;
    job_nonce_end = j.nonce_end;
    tick();
    job_valid = 1'b0;
    core_req_ready = 1'b1;
    tick();
    tick();
    check("mid_busy_before", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_job_ready", job_ready, 1'b1);
    check("mid_rst_core_data", core_data, '0);
    check("mid_rst_req_valid", core_req_valid, 1'b0);
    core_req_ready = 1'b0;
    tick();
    check("mid_rst_no_done", done, 1'b0);
    rst_n = 1'b1;
    tick();
    $display("reset mid-scan: busy=%0b job_ready=%0b", busy, job_ready);

    // Spurious result in IDLE sets the sticky protocol error.
    core_res_valid = 1'b1;
    core_res_hit = 1'b1;
    core_res_nonce = 32'h77;
    tick();
    core_res_valid = 1'b0;
    core_res_hit = 1'b0;
    check("proto_set", proto_err, 1'b1);
    check("proto_no_count", hash_count, 32'd0);
    check("proto_no_found", found_valid, 1'b0);
    tick();
    tick();
    check("proto_sticky", proto_err, 1'b1);
    $display("spurious result: proto_err=%0b hash_count=%0d", proto_err, hash_count);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
